// File: rtl/gs_elim_seq_pkg.sv
// gs_elim_seq shared state encoding and width helpers.
// GS_ELIM_SYS_EN adds the back-substitution states.
`ifndef GS_CLOG2
`define GS_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package gs_elim_seq_pkg;

`ifdef GS_ELIM_SYS_EN
  typedef enum logic [2:0] {
    IDLE,
    TRI_RD,
    TRI_SW,
    TRI_WR,
    SYS_RD,
    SYS_SW,
    SYS_WR
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE,
    TRI_RD,
    TRI_SW,
    TRI_WR
  } state_e;
`endif

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/gs_elim_seq_if.sv
// SA and row-memory bundle driven by the gs_elim_seq sequencer.
// The master drives control/address, the slave returns pivot counts.
interface gs_elim_seq_if #(
  parameter int K = 32,
  parameter int D = 4
);
  import gs_elim_seq_pkg::*;

  localparam int AW = `GS_CLOG2(K);
  localparam int PW = `GS_CLOG2(D + 1);

  logic          sa_mode;
  logic          sa_start;
  logic          sa_swap;
  logic [PW-1:0] sa_piv_cnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;

  modport master (
    output sa_mode,
    output sa_start,
    output sa_swap,
    output mem_addr,
    output mem_we,
    input  sa_piv_cnt
  );

  modport slave (
    input  sa_mode,
    input  sa_start,
    input  sa_swap,
    input  mem_addr,
    input  mem_we,
    output sa_piv_cnt
  );
endinterface

// File: rtl/gs_elim_addr_gen.sv
// Row address counter: loads base/limit, steps up or down,
// and holds at the limit so an address never runs past it.
module gs_elim_addr_gen
  import gs_elim_seq_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic          dir_i,
  input  logic [AW-1:0] base_i,
  input  logic [AW-1:0] limit_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] lim_q, lim_d;

  assign addr_o = addr_q;
  assign last_o = (addr_q == lim_q);

  always_comb begin
    addr_d = addr_q;
    lim_d  = lim_q;
    if (load_i) begin
      addr_d = base_i;
      lim_d  = limit_i;
    end else if (step_i && !last_o) begin
      addr_d = dir_i ? addr_q - AW'(1)
                     : addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      lim_q  <= '0;
    end else begin
      addr_q <= addr_d;
      lim_q  <= lim_d;
    end
  end
endmodule

// File: rtl/gs_elim_seq.sv
// Blocked GF(2) Gauss elimination sequencer (SA + row RAM control).
// Define GS_ELIM_SYS_EN to add back-substitution rounds after TRI.
module gs_elim_seq
  import gs_elim_seq_pkg::*;
#(
  parameter int K          = 32,
  parameter int L          = 32,
  parameter int D          = 4,
  parameter int READ_DELAY = 2,
  localparam int AW = `GS_CLOG2(K),
  localparam int RW = `GS_CLOG2(K + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rank,
  output logic          full_rank,
  gs_elim_seq_if.master sa
);
  localparam int CW = $clog2(K + L + D + READ_DELAY + 1);
  localparam logic [CW-1:0] KC  = CW'(K);
  localparam logic [CW-1:0] DC  = CW'(D);
  localparam logic [CW-1:0] RDC = CW'(READ_DELAY);
  localparam logic [CW-1:0] DRN = CW'(L - D);
`ifdef GS_ELIM_SYS_EN
  localparam int R = ceil_div(K, D);
  localparam logic [CW-1:0] SWL = CW'(L + D - 3);
  localparam logic [RW-1:0] TOP2 = RW'((R - 1) * D);
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] ptr_w, nr;
  logic [RW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] rank_q, rank_d;
  logic          done_q, done_d;

  logic          ag_load, ag_step, ag_last;
  logic [AW-1:0] ag_base, ag_lim, ag_addr;

  gs_elim_addr_gen #(.AW(AW)) u_ag (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ag_load),
    .step_i  (ag_step),
    .dir_i   (1'b0),
    .base_i  (ag_base),
    .limit_i (ag_lim),
    .addr_o  (ag_addr),
    .last_o  (ag_last)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rank      = rank_q;
  assign full_rank = (rank_q == RW'(K));

  // ptr_q is the round base in TRI and the row count in SYS
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    ptr_d   = ptr_q;
    rank_d  = rank_q;
    done_d  = 1'b0;
    ag_load = 1'b0;
    ag_step = 1'b0;
    ag_base = '0;
    ag_lim  = AW'(K - 1);
    sa.sa_mode  = 1'b0;
    sa.sa_start = 1'b0;
    sa.sa_swap  = 1'b0;
    sa.mem_we   = 1'b0;
    sa.mem_addr = '0;
    ptr_w = CW'(ptr_q);
    nr    = KC - ptr_w;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = TRI_RD;
          ptr_d   = '0;
          rank_d  = '0;
          ag_load = 1'b1;
        end
      end
      TRI_RD: begin
        if (cnt_q < nr) begin
          ag_step     = 1'b1;
          sa.mem_addr = ag_addr;
        end
        sa.sa_start = (cnt_q == RDC);
        if (cnt_q == nr + RDC - CW'(1)) begin
          state_d = TRI_SW;
          cnt_d   = '0;
        end
      end
      TRI_SW: begin
        sa.sa_swap = 1'b1;
        if (cnt_q == DC - CW'(1)) begin
          rank_d  = rank_q + RW'(sa.sa_piv_cnt);
          state_d = TRI_WR;
          cnt_d   = '0;
          ag_load = 1'b1;
          ag_base = AW'(ptr_q);
        end
      end
      TRI_WR: begin
        if (cnt_q >= DRN) begin
          sa.mem_we   = 1'b1;
          sa.mem_addr = ag_addr;
          ag_step     = 1'b1;
          if (ag_last) begin
            cnt_d = '0;
            if (ptr_w + DC >= KC) begin
`ifdef GS_ELIM_SYS_EN
              if (rank_q == RW'(K)) begin
                state_d = SYS_RD;
                ptr_d   = RW'(K);
                ag_load = 1'b1;
              end else
`endif
              begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              state_d = TRI_RD;
              ptr_d   = ptr_q + RW'(D);
              ag_load = 1'b1;
              ag_base = AW'(ptr_q + RW'(D));
            end
          end
        end
      end
`ifdef GS_ELIM_SYS_EN
      SYS_RD: begin
        sa.sa_mode = 1'b1;
        if (cnt_q < ptr_w) begin
          ag_step     = 1'b1;
          sa.mem_addr = ag_addr;
        end
        sa.sa_start = (cnt_q == RDC);
        if (cnt_q == ptr_w + RDC - CW'(1)) begin
          state_d = SYS_SW;
          cnt_d   = '0;
        end
      end
      SYS_SW: begin
        sa.sa_mode = 1'b1;
        sa.sa_swap = 1'b1;
        if (cnt_q == SWL) begin
          state_d = SYS_WR;
          cnt_d   = '0;
          ag_load = 1'b1;
          ag_lim  = AW'(ptr_q - RW'(1));
        end
      end
      SYS_WR: begin
        sa.sa_mode  = 1'b1;
        sa.mem_we   = 1'b1;
        sa.mem_addr = ag_addr;
        ag_step     = 1'b1;
        if (ag_last) begin
          cnt_d = '0;
          if (ptr_q <= RW'(D)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            ptr_d   = (ptr_q == RW'(K)) ? TOP2
                                        : ptr_q - RW'(D);
            state_d = SYS_RD;
            ag_load = 1'b1;
            ag_lim  = AW'(ptr_d - RW'(1));
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
      rank_d  = rank_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      rank_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      rank_q  <= rank_d;
      done_q  <= done_d;
    end
  end
endmodule
